booth_seq_ctrl: RTL and testbench

Sequencing controller for the radix-4 Booth multiplier datapath: 8-bit multiplicand register, 16-bit product/multiplier register, 3-bit Booth window and 3-bit iteration counter. On a `start` request it pulses the datapath load, runs four add/shift iterations driven by the 6-bit `status` word (`{cnt[2:0], x[2:0]}`), then signals `done`. It is the only driver of the datapath control strobes (`control`, `xld`, `cntld`, `pld`, `ald`, `funsel`) and of the datapath's load/reset line.

---
 rtl/booth_pkg.sv | 26 ++
 rtl/booth_recode.sv | 22 ++
 rtl/booth_seq_ctrl.sv | 111 +++++++++++
 tb/tb_booth_seq_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth sequencing controller.
package booth_pkg;

    // Controller states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // ALU op encodings: [2] adds +A, [1] adds +2A, [0] negates
    localparam logic [2:0] FUN_ZERO = 3'b000;
    localparam logic [2:0] FUN_PA   = 3'b100;
    localparam logic [2:0] FUN_P2A  = 3'b010;
    localparam logic [2:0] FUN_MA   = 3'b101;
    localparam logic [2:0] FUN_M2A  = 3'b011;

    // Field positions inside the datapath status word {cnt, x}
    localparam int unsigned ST_CNT_MSB = 5;
    localparam int unsigned ST_CNT_LSB = 3;
    localparam int unsigned ST_X_MSB   = 2;
    localparam int unsigned ST_X_LSB   = 0;

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: 3-bit window {b(i+1), b(i), b(i-1)} to ALU op.
module booth_recode
    import booth_pkg::*;
(
    input  logic [2:0] x_i,
    output logic [2:0] funsel_o
);

    // Window to signed digit {0, +1, +2, -2, -1} expressed as ALU op
    always_comb begin
        funsel_o = FUN_ZERO;
        unique case (x_i)
            3'b000, 3'b111: funsel_o = FUN_ZERO;
            3'b001, 3'b010: funsel_o = FUN_PA;
            3'b011:         funsel_o = FUN_P2A;
            3'b100:         funsel_o = FUN_M2A;
            3'b101, 3'b110: funsel_o = FUN_MA;
            default:        funsel_o = FUN_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencing controller for the radix-4 Booth multiplier datapath.
// Runs LOAD, then N_ITER ADD/SHIFT pairs, a final ADD that observes the
// terminal count, and a one-cycle DONE.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int unsigned N_ITER = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] status,
    output logic       dp_reset,
    output logic       control,
    output logic [2:0] funsel,
    output logic       xld,
    output logic       cntld,
    output logic       pld,
    output logic       ald,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] N_ITER_C = 3'(N_ITER);

    state_e     state_q, state_d;
    logic       err_q, err_d;
    logic [2:0] cnt;
    logic [2:0] x;
    logic [2:0] rec_funsel;
    logic       cnt_end;
    logic       cnt_over;

    assign cnt      = status[ST_CNT_MSB:ST_CNT_LSB];
    assign x        = status[ST_X_MSB:ST_X_LSB];
    assign cnt_end  = (cnt >= N_ITER_C);
    assign cnt_over = (cnt > N_ITER_C);

    booth_recode u_recode (
        .x_i      (x),
        .funsel_o (rec_funsel)
    );

    // Next-state and sticky error logic
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_ADD;
            S_ADD: begin
                if (cnt_end) begin
                    state_d = S_DONE;
                    if (cnt_over) err_d = 1'b1;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: state_d = S_ADD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and error registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Strobe decode from current state; funsel in ADD follows status directly
    always_comb begin
        dp_reset = 1'b0;
        control  = 1'b0;
        funsel   = FUN_ZERO;
        xld      = 1'b0;
        cntld    = 1'b0;
        pld      = 1'b0;
        ald      = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);
        err      = err_q;
        unique case (state_q)
            S_IDLE:  ;
            S_LOAD:  dp_reset = 1'b1;
            S_ADD: begin
                // Terminal count loads nothing, so funsel stays at zero too
                if (!cnt_end) begin
                    control = 1'b0;
                    pld     = 1'b1;
                    funsel  = rec_funsel;
                end
            end
            S_SHIFT: begin
                control = 1'b1;
                pld     = 1'b1;
                xld     = 1'b1;
                cntld   = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: behavioural datapath, schedule
// model of the controller, per-cycle output compare and directed cases.
module tb_booth_seq_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [5:0] status;
    logic       dp_reset, control, xld, cntld, pld, ald, busy, done, err;
    logic [2:0] funsel;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    booth_seq_ctrl #(.N_ITER(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .status   (status),
        .dp_reset (dp_reset),
        .control  (control),
        .funsel   (funsel),
        .xld      (xld),
        .cntld    (cntld),
        .pld      (pld),
        .ald      (ald),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural datapath ----------------
    logic [7:0]        ain = '0, pin = '0;
    logic signed [7:0] a_r = '0, m_r = '0;
    int                acc = 0;
    logic [2:0]        cnt_r = '0, x_r = '0;
    int                force_cnt = -1, force_x = -1;
    int                pld_n = 0, cntld_n = 0, dpr_n = 0;

    function automatic logic [2:0] window(input logic signed [7:0] m, input int i);
        logic [17:0] e;
        e = {{9{m[7]}}, m, 1'b0};
        return e[2*i+2 -: 3];
    endfunction

    function automatic int fun2digit(input logic [2:0] f);
        int d;
        d = (f[2] ? 1 : 0) + (f[1] ? 2 : 0);
        return f[0] ? -d : d;
    endfunction

    // Expected ALU op from a window: signed digit -2*b2 + b1 + b0
    function automatic logic [2:0] exp_fun(input logic [2:0] xw);
        int d;
        d = -2 * int'(xw[2]) + int'(xw[1]) + int'(xw[0]);
        case (d)
            1:       return 3'b100;
            2:       return 3'b010;
            -1:      return 3'b101;
            -2:      return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    assign status = {(force_cnt >= 0) ? 3'(force_cnt) : cnt_r,
                     (force_x   >= 0) ? 3'(force_x)   : x_r};

    wire [15:0] p = acc[15:0];

    always @(posedge clk) begin
        pld_n   <= pld_n   + (pld      ? 1 : 0);
        cntld_n <= cntld_n + (cntld    ? 1 : 0);
        dpr_n   <= dpr_n   + (dp_reset ? 1 : 0);
        if (dp_reset) begin
            a_r   <= ain;
            m_r   <= pin;
            acc   <= 0;
            cnt_r <= '0;
            x_r   <= {pin[1:0], 1'b0};
        end else begin
            if (pld && !control)
                acc <= acc + fun2digit(funsel) * int'(a_r) * (1 << (2 * int'(cnt_r)));
            if (xld && cntld) begin
                cnt_r <= cnt_r + 3'd1;
                x_r   <= window(m_r, int'(cnt_r) + 1);
            end
        end
    end

    // ---------------- controller schedule model ----------------
    // ph: 0 idle, 1 load, even>=2 add slot, odd>=3 shift slot, -1 done
    int ph    = 0;
    bit err_m = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            ph    <= 0;
            err_m <= 1'b0;
        end else if (ph == 0) begin
            if (start) ph <= 1;
        end else if (ph == 1) begin
            ph <= 2;
        end else if (ph == -1) begin
            ph <= 0;
        end else if (ph % 2 == 0) begin
            if (int'(status[5:3]) > N) begin
                err_m <= 1'b1;
                ph    <= -1;
            end else if (int'(status[5:3]) == N) begin
                ph <= -1;
            end else begin
                ph <= ph + 1;
            end
        end else begin
            ph <= ph + 1;
        end
    end

    function automatic logic [11:0] exp_vec(input int phase, input logic [5:0] st, input bit e);
        logic       r, c, xl, cl, pl, bz, dn;
        logic [2:0] f;
        r = 0; c = 0; xl = 0; cl = 0; pl = 0; dn = 0; f = 3'b000;
        bz = (phase != 0);
        if (phase == 1) r = 1;
        else if (phase == -1) dn = 1;
        else if (phase >= 2 && phase % 2 == 0) begin
            if (int'(st[5:3]) < N) begin
                pl = 1;
                f  = exp_fun(st[2:0]);
            end
        end else if (phase >= 3) begin
            c = 1; pl = 1; xl = 1; cl = 1;
        end
        return {r, c, f, xl, cl, pl, 1'b0, bz, dn, e};
    endfunction

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (cmp_en)
            check("outputs", int'({dp_reset, control, funsel, xld, cntld, pld, ald, busy, done, err}),
                  int'(exp_vec(ph, status, err_m)));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string nm, output int n);
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        if (!done) check({nm, "_timeout"}, 0, 1);
    endtask

    task automatic run_mult(input logic [7:0] av, input logic [7:0] pv,
                            input logic [15:0] exp_p, input string nm);
        int n, p0, c0, d0;
        ain = av;
        pin = pv;
        p0 = pld_n; c0 = cntld_n; d0 = dpr_n;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(nm, n);
        check({nm, "_latency"}, n, 11);
        check({nm, "_product"}, int'(p), int'(exp_p));
        check({nm, "_pld_count"}, pld_n - p0, 8);
        check({nm, "_cntld_count"}, cntld_n - c0, 4);
        check({nm, "_dpreset_count"}, dpr_n - d0, 1);
        tick();
    endtask

    localparam logic [2:0] REC_LIT [8] = '{3'b000, 3'b100, 3'b100, 3'b010,
                                           3'b011, 3'b101, 3'b101, 3'b000};

    initial begin
        int n;
        int loads[$];
        logic [7:0] ra, rp;

        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        cmp_en = 1'b1;
        check("reset_outputs", int'({dp_reset, control, funsel, xld, cntld, pld, ald, busy, done, err}), 0);
        reset = 1'b0;
        tick();

        // Directed products with literal expectations
        run_mult(8'd7, 8'd3, 16'h0015, "mul_7x3");
        run_mult(8'hF9, 8'h05, 16'hFFDD, "mul_m7x5");

        // Recode sweep across two runs, forcing the window in each ADD slot
        for (int r = 0; r < 2; r++) begin
            ain = 8'd1; pin = 8'd1;
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            for (int j = 0; j < 4; j++) begin
                force_x = r * 4 + j;
                #1;
                check("recode", int'(funsel), int'(REC_LIT[r * 4 + j]));
                tick();
                tick();
            end
            force_x = -1;
            wait_done("recode_run", n);
            tick();
        end

        // Reset in cycle 5, then a clean multiply
        ain = 8'd9; pin = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("midreset_idle", int'({dp_reset, control, funsel, xld, cntld, pld, busy, done}), 0);
        tick();
        run_mult(8'd12, 8'hFD, 16'hFFDC, "after_reset");

        // start held high: one LOAD every 12 cycles
        start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (dp_reset) loads.push_back(k);
        end
        start = 1'b0;
        check("held_load_count", loads.size(), 3);
        if (loads.size() >= 3) begin
            check("held_spacing_1", loads[1] - loads[0], 12);
            check("held_spacing_2", loads[2] - loads[1], 12);
        end
        wait_done("held_drain", n);
        tick();

        // Protocol error: out-of-range count during ADD
        ain = 8'd3; pin = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        force_cnt = 5;
        #1;
        check("err_add_funsel", int'(funsel), 0);
        tick();
        force_cnt = -1;
        check("err_done", int'(done), 1);
        check("err_set", int'(err), 1);
        tick();
        run_mult(8'd5, 8'd6, 16'h001E, "after_err");
        check("err_sticky", int'(err), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("err_cleared", int'(err), 0);
        tick();

        // Randomized multiplies against signed arithmetic
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rp = 8'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            run_mult(ra, rp, 16'(int'($signed(ra)) * int'($signed(rp))), "random");
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
